cond_inv_pipe: RTL

Multi-channel, parametrised successor to the single-bit conditional-invert register (out <= sel ? !in : in).
- Each accepted beat carries CHANNELS lanes of WIDTH bits.
- A per-beat mode and a per-lane select decide inversion.
- Results are buffered in a 2-entry output queue with valid/ready handshakes on both sides.
- A saturating counter reports how many lanes were inverted.
- Sits between a data producer and a consumer that may stall.

---
 rtl/cond_inv_pipe.sv | 94 +++++++++
 1 files changed

// File: rtl/cond_inv_pipe.sv
// Per-lane conditional invert into a 2-entry output queue; result visible the cycle after accept.
// in_ready drops only when both entries are held; out_data holds steady while the consumer stalls.
module cond_inv_pipe #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_sel,
    input  logic [1:0]                mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    input  logic                      cnt_clr,
    output logic [CNT_W-1:0]          inv_count
);
    localparam int DW = CHANNELS * WIDTH;
    localparam int PW = $clog2(CHANNELS + 1);

    logic [DW-1:0]       r_mem [2];
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [1:0]          r_occ;
    logic                r_in_rdy;
    logic [CNT_W-1:0]    r_cnt;

    logic [DW-1:0]       w_res;
    logic [CHANNELS-1:0] w_inv;
    logic [PW-1:0]       w_ninv;
    logic                w_push;
    logic                w_pop;
    logic [1:0]          w_occ_nxt;
    logic [CNT_W:0]      w_sum;

    always_comb begin
        w_res  = '0;
        w_inv  = '0;
        w_ninv = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            case (mode)
                2'b00:   w_inv[c] = 1'b0;
                2'b01:   w_inv[c] = in_sel[c];
                2'b10:   w_inv[c] = 1'b1;
                default: w_inv[c] = ~in_sel[c];
            endcase
            w_res[c*WIDTH +: WIDTH] = w_inv[c] ? ~in_data[c*WIDTH +: WIDTH]
                                               :  in_data[c*WIDTH +: WIDTH];
            w_ninv = w_ninv + PW'(w_inv[c]);
        end
    end

    assign w_push    = in_valid & r_in_rdy;
    assign w_pop     = (r_occ != 2'd0) & out_ready;
    assign w_occ_nxt = r_occ + {1'b0, w_push} - {1'b0, w_pop};
    assign w_sum     = {1'b0, r_cnt} + (CNT_W+1)'(w_ninv);

    // in_ready is registered from the next occupancy, so it never sees out_ready combinationally
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
            r_in_rdy <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_res;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_occ    <= w_occ_nxt;
            r_in_rdy <= (w_occ_nxt != 2'd2);
            if (cnt_clr) begin
                r_cnt <= w_push ? CNT_W'(w_ninv) : '0;
            end else if (w_push) begin
                r_cnt <= w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
            end
        end
    end

    assign in_ready  = r_in_rdy;
    assign out_valid = (r_occ != 2'd0);
    assign out_data  = r_mem[r_rd_ptr];
    assign inv_count = r_cnt;

endmodule
